// File: rtl/spi_adc_if.sv
// SPI link between a controller and the ADC responder: mode-0 clock, active-low select, MOSI/MISO.
interface spi_adc_if;
  logic sclk_i;
  logic cs_i;
  logic data_i;
  logic data_o;
  logic data_oe;

  modport master (output sclk_i, cs_i, data_i, input data_o, data_oe);
  modport slave  (input sclk_i, cs_i, data_i, output data_o, data_oe);
endinterface

// File: rtl/spi_adc_responder.sv
// MCP3002-style 2-channel ADC responder: decodes the start/SGL/ODD/MSBF command from MOSI
// and shifts back a null bit plus a held single-ended or saturated differential conversion.
module spi_adc_responder #(
  parameter int unsigned WIDTH       = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  spi_adc_if.slave         spi,
  input  logic [WIDTH-1:0] ch0_sample_i,
  input  logic [WIDTH-1:0] ch1_sample_i,
  output logic [2:0]       cmd_o,
  output logic             busy,
  output logic             frame_done,
  output logic             abort
);
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_NULL  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_TRAIL = 3'd5;

  // Input synchronizers plus one extra sample for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.data_i};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  logic [2:0]       state, state_n;
  logic             armed, armed_n;
  logic [1:0]       cmd_sh, cmd_sh_n;
  logic [1:0]       cmd_cnt, cmd_cnt_n;
  logic [2:0]       cmd_n;
  logic [WIDTH-1:0] hold0, hold0_n, hold1, hold1_n;
  logic [WIDTH-1:0] res, res_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             lsb_phase, lsb_phase_n;
  logic             done_pend, done_pend_n;
  logic             data_q, data_n, oe_q, oe_n;
  logic             busy_n, fd_n, abort_n;

  // Conversion result from the held samples and the accepted {SGL, ODD, MSBF}
  logic [WIDTH-1:0] op_a, op_b, result_c;
  logic [WIDTH:0]   diff_c;

  always_comb begin
    op_a     = cmd_o[1] ? hold1 : hold0;
    op_b     = cmd_o[1] ? hold0 : hold1;
    diff_c   = {1'b0, op_a} - {1'b0, op_b};
    result_c = op_a;
    if (!cmd_o[2]) result_c = diff_c[WIDTH] ? '0 : diff_c[WIDTH-1:0];
  end

  always_comb begin
    state_n     = state;
    armed_n     = armed;
    cmd_sh_n    = cmd_sh;
    cmd_cnt_n   = cmd_cnt;
    cmd_n       = cmd_o;
    hold0_n     = hold0;
    hold1_n     = hold1;
    res_n       = res;
    idx_n       = idx;
    lsb_phase_n = lsb_phase;
    done_pend_n = done_pend;
    data_n      = data_q;
    fd_n        = 1'b0;
    abort_n     = 1'b0;

    // A cs release outranks any sclk edge seen in the same cycle
    if (cs_rise && state != S_IDLE) begin
      state_n = S_IDLE;
      abort_n = (state != S_TRAIL);
      data_n  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state_n     = S_START;
            armed_n     = ~sclk_s;
            cmd_cnt_n   = '0;
            lsb_phase_n = 1'b0;
            done_pend_n = 1'b0;
            data_n      = 1'b0;
          end
        end
        S_START: begin
          data_n = 1'b0;
          if (sclk_fall) begin
            armed_n = 1'b1;
          end else if (sclk_rise && armed && mosi_s) begin
            state_n   = S_CMD;
            hold0_n   = ch0_sample_i;
            hold1_n   = ch1_sample_i;
            cmd_cnt_n = '0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            cmd_sh_n  = {cmd_sh[0], mosi_s};
            cmd_cnt_n = cmd_cnt + 2'd1;
            if (cmd_cnt == 2'd2) begin
              cmd_n   = {cmd_sh, mosi_s};
              state_n = S_NULL;
            end
          end
        end
        S_NULL: begin
          if (sclk_fall) begin
            data_n      = 1'b0;
            res_n       = result_c;
            idx_n       = IDX_W'(WIDTH - 1);
            lsb_phase_n = 1'b0;
            done_pend_n = 1'b0;
            state_n     = S_DATA;
          end
        end
        S_DATA: begin
          // MSB-first pass, then optionally bits 1..WIDTH-1 LSB-first
          if (sclk_fall && !done_pend) begin
            data_n = res[idx];
            if (!lsb_phase) begin
              if (idx == '0) begin
                if (cmd_o[0]) begin
                  done_pend_n = 1'b1;
                end else begin
                  lsb_phase_n = 1'b1;
                  idx_n       = IDX_W'(1);
                end
              end else begin
                idx_n = idx - IDX_W'(1);
              end
            end else if (idx == IDX_W'(WIDTH - 1)) begin
              done_pend_n = 1'b1;
            end else begin
              idx_n = idx + IDX_W'(1);
            end
          end else if (sclk_rise && done_pend) begin
            fd_n    = 1'b1;
            state_n = S_TRAIL;
          end
        end
        S_TRAIL: begin
          if (sclk_fall) data_n = 1'b0;
        end
        default: state_n = S_IDLE;
      endcase
    end

    oe_n   = (state_n != S_IDLE);
    busy_n = oe_n;
    if (!oe_n) data_n = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      armed      <= 1'b0;
      cmd_sh     <= '0;
      cmd_cnt    <= '0;
      cmd_o      <= '0;
      hold0      <= '0;
      hold1      <= '0;
      res        <= '0;
      idx        <= '0;
      lsb_phase  <= 1'b0;
      done_pend  <= 1'b0;
      data_q     <= 1'b0;
      oe_q       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state      <= state_n;
      armed      <= armed_n;
      cmd_sh     <= cmd_sh_n;
      cmd_cnt    <= cmd_cnt_n;
      cmd_o      <= cmd_n;
      hold0      <= hold0_n;
      hold1      <= hold1_n;
      res        <= res_n;
      idx        <= idx_n;
      lsb_phase  <= lsb_phase_n;
      done_pend  <= done_pend_n;
      data_q     <= data_n;
      oe_q       <= oe_n;
      busy       <= busy_n;
      frame_done <= fd_n;
      abort      <= abort_n;
    end
  end

  assign spi.data_o  = data_q;
  assign spi.data_oe = oe_q;
endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: plays the SPI controller and checks MISO words and status pulses.
module tb_spi_adc_responder;
  localparam int HALF = 8;

  logic       clk;
  logic       rst;
  logic [9:0] ch0, ch1;
  logic [2:0] cmd;
  logic       busy, frame_done, abort;

  spi_adc_if bus ();

  spi_adc_responder #(.WIDTH(10), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi          (bus),
    .ch0_sample_i (ch0),
    .ch1_sample_i (ch1),
    .cmd_o        (cmd),
    .busy         (busy),
    .frame_done   (frame_done),
    .abort        (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int fd_cnt = 0;
  int ab_cnt = 0;
  always @(posedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (abort)      ab_cnt <= ab_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.cs_i = 1'b0;
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    bus.cs_i   = 1'b1;
    bus.data_i = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // One sclk cycle per MOSI bit; MISO is sampled just before each rise
  task automatic frame_bits(input logic [31:0] mosi, input int nbits, input int chg_bit,
                            input logic [9:0] chg_val, output logic [31:0] miso, output int fd_bit);
    int fd0;
    fd0    = fd_cnt;
    miso   = '0;
    fd_bit = -1;
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) ch1 = chg_val;
      bus.data_i = mosi[nbits-1-i];
      repeat (HALF) @(negedge clk);
      miso = {miso[30:0], bus.data_o};
      bus.sclk_i = 1'b1;
      repeat (HALF) @(negedge clk);
      if (fd_bit < 0 && fd_cnt != fd0) fd_bit = i;
      bus.sclk_i = 1'b0;
    end
  endtask

  logic [31:0] miso;
  int          fdb, fd0, ab0;

  initial begin
    rst        = 1'b0;
    bus.sclk_i = 1'b0;
    bus.cs_i   = 1'b1;
    bus.data_i = 1'b0;
    ch0        = '0;
    ch1        = '0;
    #23;
    check("rst_data_o", 32'(bus.data_o), 32'd0);
    check("rst_data_oe", 32'(bus.data_oe), 32'd0);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Scenario 1: single-ended ch0, MSB first
    ch0 = 10'h2A5; ch1 = 10'h000;
    fd0 = fd_cnt; ab0 = ab_cnt;
    cs_low();
    repeat (6) @(negedge clk);
    check("s1_busy", 32'(busy), 32'd1);
    check("s1_oe", 32'(bus.data_oe), 32'd1);
    frame_bits(32'(4'b1101) << 12, 16, -1, 10'h0, miso, fdb);
    cs_high();
    check("s1_miso", miso, 32'({5'b0, 10'h2A5, 1'b0}));
    check("s1_cmd", 32'(cmd), 32'b101);
    check("s1_fd_bit", 32'(fdb), 32'd14);
    check("s1_fd_cnt", 32'(fd_cnt - fd0), 32'd1);
    check("s1_abort", 32'(ab_cnt - ab0), 32'd0);
    check("s1_idle_busy", 32'(busy), 32'd0);

    // Scenario 2: ch1 all ones, changed mid-frame
    ch0 = 10'h155; ch1 = 10'h3FF;
    cs_low();
    frame_bits(32'(4'b1111) << 12, 16, 8, 10'h000, miso, fdb);
    cs_high();
    check("s2_miso", miso, 32'({5'b0, 10'h3FF, 1'b0}));
    check("s2_cmd", 32'(cmd), 32'b111);

    // Scenario 3: differential, positive and saturated
    ch0 = 10'd100; ch1 = 10'd300;
    cs_low();
    frame_bits(32'(4'b1011) << 12, 16, -1, 10'h0, miso, fdb);
    cs_high();
    check("s3_diff_miso", miso, 32'({5'b0, 10'd200, 1'b0}));
    check("s3_diff_cmd", 32'(cmd), 32'b011);
    cs_low();
    frame_bits(32'(4'b1001) << 12, 16, -1, 10'h0, miso, fdb);
    cs_high();
    check("s3_sat_miso", miso, 32'({5'b0, 10'd0, 1'b0}));
    check("s3_sat_cmd", 32'(cmd), 32'b001);

    // Scenario 4: LSB-first tail
    ch0 = 10'h201; ch1 = 10'h0F0;
    fd0 = fd_cnt;
    cs_low();
    frame_bits(32'(4'b1100) << 21, 25, -1, 10'h0, miso, fdb);
    cs_high();
    check("s4_miso", miso, 32'({5'b0, 10'h201, 9'b000000001, 1'b0}));
    check("s4_fd_bit", 32'(fdb), 32'd23);
    check("s4_fd_cnt", 32'(fd_cnt - fd0), 32'd1);

    // Scenario 5: three leading zeros before the start bit
    ch0 = 10'h2A5; ch1 = 10'h000;
    cs_low();
    frame_bits(32'(7'b0001101) << 12, 19, -1, 10'h0, miso, fdb);
    cs_high();
    check("s5_miso", miso, 32'({8'b0, 10'h2A5, 1'b0}));
    check("s5_fd_bit", 32'(fdb), 32'd17);

    // cs falls together with an sclk rise carrying a 1: that rise must not count
    @(negedge clk);
    bus.data_i = 1'b1;
    bus.sclk_i = 1'b1;
    bus.cs_i   = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.sclk_i = 1'b0;
    frame_bits(32'(4'b1101) << 12, 16, -1, 10'h0, miso, fdb);
    cs_high();
    check("sh_miso", miso, 32'({5'b0, 10'h2A5, 1'b0}));
    check("sh_cmd", 32'(cmd), 32'b101);

    // Scenario 6a: cs released after 5 data bits
    fd0 = fd_cnt; ab0 = ab_cnt;
    cs_low();
    frame_bits(32'(4'b1101) << 5, 9, -1, 10'h0, miso, fdb);
    cs_high();
    check("s6_abort_cnt", 32'(ab_cnt - ab0), 32'd1);
    check("s6_fd_cnt", 32'(fd_cnt - fd0), 32'd0);
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_oe", 32'(bus.data_oe), 32'd0);
    check("s6_partial_miso", miso, 32'({5'b0, 4'b1010}));

    // Scenario 6b: reset asserted mid-DATA while MISO is high
    ch0 = 10'h2A5;
    cs_low();
    frame_bits(32'(4'b1101) << 5, 9, -1, 10'h0, miso, fdb);
    repeat (HALF) @(negedge clk);
    check("s6_pre_rst_data_o", 32'(bus.data_o), 32'd1);
    rst = 1'b0;
    #1;
    check("s6_rst_data_o", 32'(bus.data_o), 32'd0);
    check("s6_rst_oe", 32'(bus.data_oe), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_cmd", 32'(cmd), 32'd0);
    check("s6_rst_fd", 32'(frame_done), 32'd0);
    check("s6_rst_abort", 32'(abort), 32'd0);
    repeat (3) @(negedge clk);
    bus.cs_i   = 1'b1;
    bus.data_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    // Scenario 6c: clean frame after reset, single-ended ch1
    ch0 = 10'h0AA; ch1 = 10'h155;
    fd0 = fd_cnt;
    cs_low();
    frame_bits(32'(4'b1111) << 12, 16, -1, 10'h0, miso, fdb);
    cs_high();
    check("s6_post_miso", miso, 32'({5'b0, 10'h155, 1'b0}));
    check("s6_post_cmd", 32'(cmd), 32'b111);
    check("s6_post_fd_cnt", 32'(fd_cnt - fd0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_adc_responder.md
Name: spi_adc_responder

Overview:
- Behavioural/synthesizable SPI peripheral that models a 2-channel, 10-bit ADC of the MCP3002 type.
- It is the responder end of the link driven by spi_controller.
- It watches sclk/cs/MOSI, decodes the 4-bit command and returns a 10-bit conversion on MISO.
- Used in loop-back benches and FPGA self-test in place of the real ADC.

Parameters:
- WIDTH, 10, conversion word width.
- SYNC_STAGES, 2, synchronizer flops on sclk_i, cs_i, data_i (minimum 2).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, asynchronous and active-low (0 = reset).
- sclk_i  input  1  SPI clock from the controller, mode 0.
- cs_i  input  1  chip select, active-low.
- data_i  input  1  MOSI, command bits.
- data_o  output  1  MISO.
- data_oe  output  1  MISO drive enable.
- ch0_sample_i  input  WIDTH  analog value for channel 0.
- ch1_sample_i  input  WIDTH  analog value for channel 1.
- cmd_o  output  3  last accepted {SGL, ODD, MSBF}.
- busy  output  1  frame in progress.
- frame_done  output  1  1-clk pulse, frame completed normally.
- abort  output  1  1-clk pulse, cs released before the last data bit.

Behaviour:
- **Reset (rst=0):**
  - data_o=0, data_oe=0, cmd_o=0, busy=0, frame_done=0, abort=0.
  - State=IDLE; shift registers and bit counter cleared. Effect is immediate and asynchronous.
- **Input conditioning:**
  - sclk_i, cs_i and data_i each pass through SYNC_STAGES flops.
  - Rise/fall of sclk and cs are detected from the last two synchronized samples.
  - sclk high and low phases must each be ≥ SYNC_STAGES+2 clk; shorter phases are unsupported.
- **Bit timing (mode 0):**
  - MOSI is sampled on the synchronized sclk rise.
  - MISO changes on the synchronized sclk fall, within SYNC_STAGES+1 clk of the raw fall.
- **State IDLE:** data_oe=0, busy=0. On cs fall, go to START; busy=1 and data_oe=1 from the next clk.
- **State START:**
  - On each sclk rise: data_i=0 stays in START (leading zeros allowed); data_i=1 goes to CMD.
  - On the transition to CMD, ch0_sample_i and ch1_sample_i are latched (sample/hold); later input changes do not affect this frame.
  - data_o=0.
- **State CMD:**
  - Three sclk rises shift in SGL, ODD, MSBF in that order.
  - On the third rise, cmd_o is updated and the state goes to NULL.
- **State NULL:** on the next sclk fall, drive data_o=0 (null bit), load the result word, go to DATA.
- **Result word:**
  - SGL=1: ODD=0 selects held ch0, ODD=1 selects held ch1.
  - SGL=0, ODD=0: ch0−ch1, saturated to 0 if negative.
  - SGL=0, ODD=1: ch1−ch0, saturated to 0 if negative.
  - Arithmetic is WIDTH+1 bits signed; the result is never wider than WIDTH.
- **State DATA:**
  - On each of the next WIDTH sclk falls, drive the next bit, MSB first.
  - If MSBF=0, after bit 0 continue with bits 1..WIDTH−1, LSB first: WIDTH−1 additional falls.
  - After the final bit's following sclk rise, pulse frame_done and go to TRAIL.
- **State TRAIL:** data_o=0 on subsequent falls; extra sclk cycles are ignored.
- **cs rise in any state other than IDLE:**
  - Go to IDLE, data_oe=0, busy=0 on the next clk.
  - abort pulses if the state was START, CMD, NULL or DATA; no pulse if TRAIL.
  - cmd_o keeps its last value.
- **Simultaneous events:**
  - cs rise and sclk edge detected on the same clk: the cs rise wins and the sclk edge is ignored.
  - cs fall while in IDLE with sclk high: wait for the first sclk rise after a fall; a rise already in progress does not count.
- data_oe low forces data_o=0.

Test Plan:
1. ch0=10'h2A5, ch1=0; MOSI 1,1,0,1 (start, SGL=1, ODD=0, MSBF=1), 16 sclk -> MISO after null bit reads 1010100101; frame_done pulses once; cmd_o=3'b101; abort stays 0.
2. ch1=10'h3FF, MOSI 1,1,1,1 -> 1111111111; change ch1 to 10'h000 mid-frame -> output unchanged (held value).
3. Differential: ch0=10'd100, ch1=10'd300; SGL=0, ODD=1 -> 10'd200; ODD=0 -> 10'd0 (saturated).
4. MSBF=0, ch0=10'h201 -> 1000000001 followed by 000000001 (bits 1..9 LSB first); frame_done after the 19th post-start data fall+rise.
5. Three leading zero bits before start, then SGL=1/ODD=0/MSBF=1 -> same word as scenario 1, shifted three sclk later.
6. Abort and reset:
   - cs raised after 5 data bits -> abort pulse, busy=0, data_oe=0, frame_done never pulses.
   - rst=0 mid-DATA -> all outputs 0 immediately.
   - Next full frame decodes correctly.
